// File: rtl/dispatcher_pkg.sv
// Shared definitions for the issue/dispatch stage: widths, opcodes, broadcast
// and operand records, and the register-file lookup helper.
package dispatcher_pkg;

   localparam int NUM_ROB  = 16;
   localparam int ROB_ID_W = $clog2(NUM_ROB);
   localparam int OPCODE_W = 6;
   localparam int REG_W    = 5;
   localparam int XLEN     = 32;

   localparam logic [OPCODE_W-1:0] OP_ADD  = 6'h01;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 6'h02;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 6'h03;
   localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'h08;
   localparam logic [OPCODE_W-1:0] OP_LW   = 6'h10;
   localparam logic [OPCODE_W-1:0] OP_SW   = 6'h11;

   typedef logic [ROB_ID_W-1:0] rob_id_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_HELD  = 1'b1
   } slot_state_e;

   typedef struct packed {
      logic            valid;
      rob_id_t         id;
      logic [XLEN-1:0] value;
   } bcast_t;

   typedef struct packed {
      logic [XLEN-1:0] v;
      rob_id_t         q;
      logic            r;
   } operand_t;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      rob_id_t             rob_id;
      logic                is_mem;
      logic [XLEN-1:0]     imm;
      logic [XLEN-1:0]     pc;
      operand_t            op1;
      operand_t            op2;
   } slot_t;

   function automatic logic bus_hit(bcast_t b, rob_id_t tag);
      return b.valid && (b.id == tag);
   endfunction

   // First two resolution rules: unused/x0 reads zero, an idle register reads its value.
   function automatic operand_t rf_lookup(logic use_op, logic [REG_W-1:0] rs, logic busy,
                                          rob_id_t tag, logic [XLEN-1:0] val);
      operand_t o;
      o = '0;
      if (!use_op || rs == '0) begin
         o.r = 1'b1;
      end else if (!busy) begin
         o.r = 1'b1;
         o.v = val;
      end else begin
         o.q = tag;
      end
      return o;
   endfunction

endpackage

// File: rtl/dispatcher_if.sv
// Decoder-to-dispatcher handshake plus the shared issue payload toward RS/LSB.
// valid/ready: a transfer happens on a clock edge where inst_valid && inst_ready.
interface dispatcher_if;
   import dispatcher_pkg::*;

   logic                inst_valid;
   logic                inst_ready;
   logic [OPCODE_W-1:0] inst_opcode;
   logic [REG_W-1:0]    inst_rd;
   logic [REG_W-1:0]    inst_rs1;
   logic [REG_W-1:0]    inst_rs2;
   logic                inst_use_rs1;
   logic                inst_use_rs2;
   logic                inst_is_mem;
   logic [XLEN-1:0]     inst_imm;
   logic [XLEN-1:0]     inst_pc;

   logic                is_issue;
   logic                lsb_issue;
   logic [OPCODE_W-1:0] issue_opcode;
   rob_id_t             issue_rob_id;
   logic [XLEN-1:0]     issue_Vi;
   rob_id_t             issue_Qi;
   logic                issue_Ri;
   logic [XLEN-1:0]     issue_Vj;
   rob_id_t             issue_Qj;
   logic                issue_Rj;
   logic [XLEN-1:0]     issue_imm;
   logic [XLEN-1:0]     issue_pc;

   modport master (
      output inst_valid, inst_opcode, inst_rd, inst_rs1, inst_rs2,
             inst_use_rs1, inst_use_rs2, inst_is_mem, inst_imm, inst_pc,
      input  inst_ready,
      input  is_issue, lsb_issue, issue_opcode, issue_rob_id,
             issue_Vi, issue_Qi, issue_Ri, issue_Vj, issue_Qj, issue_Rj,
             issue_imm, issue_pc
   );

   modport slave (
      input  inst_valid, inst_opcode, inst_rd, inst_rs1, inst_rs2,
             inst_use_rs1, inst_use_rs2, inst_is_mem, inst_imm, inst_pc,
      output inst_ready,
      output is_issue, lsb_issue, issue_opcode, issue_rob_id,
             issue_Vi, issue_Qi, issue_Ri, issue_Vj, issue_Qj, issue_Rj,
             issue_imm, issue_pc
   );

endinterface

// File: rtl/dispatcher_operand_resolve.sv
// Applies the three result broadcasts to one operand; alu wins over lsb over commit.
module operand_resolve
   import dispatcher_pkg::*;
(
   input  operand_t in_op,
   input  bcast_t   alu_bc,
   input  bcast_t   lsb_bc,
   input  bcast_t   commit_bc,
   output operand_t out_op
);

   always_comb begin
      out_op = in_op;
      if (in_op.r) begin
         out_op.q = '0;
      end else if (bus_hit(alu_bc, in_op.q)) begin
         out_op.r = 1'b1;
         out_op.v = alu_bc.value;
         out_op.q = '0;
      end else if (bus_hit(lsb_bc, in_op.q)) begin
         out_op.r = 1'b1;
         out_op.v = lsb_bc.value;
         out_op.q = '0;
      end else if (bus_hit(commit_bc, in_op.q)) begin
         out_op.r = 1'b1;
         out_op.v = commit_bc.value;
         out_op.q = '0;
      end
   end

endmodule

// File: rtl/dispatcher.sv
// Issue stage: accepts one decoded instruction, allocates/renames, resolves
// operands and holds them in a one-entry slot until the target queue has room.
module dispatcher
   import dispatcher_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             clear,
   dispatcher_if.slave      dif,
   output logic [REG_W-1:0] rf_rs1,
   output logic [REG_W-1:0] rf_rs2,
   input  logic             rf_busy1,
   input  logic             rf_busy2,
   input  rob_id_t          rf_tag1,
   input  rob_id_t          rf_tag2,
   input  logic [XLEN-1:0]  rf_val1,
   input  logic [XLEN-1:0]  rf_val2,
   output rob_id_t          rob_q1,
   output rob_id_t          rob_q2,
   input  logic             rob_rdy1,
   input  logic             rob_rdy2,
   input  logic [XLEN-1:0]  rob_val1,
   input  logic [XLEN-1:0]  rob_val2,
   input  logic             rob_full,
   input  rob_id_t          rob_tail,
   output logic             rob_alloc,
   output logic             rename_en,
   output logic [REG_W-1:0] rename_rd,
   output rob_id_t          rename_tag,
   input  logic             rs_full,
   input  logic             lsb_full,
   input  logic             alu_ok,
   input  rob_id_t          alu_id,
   input  logic [XLEN-1:0]  alu_res,
   input  logic             lsb_ok,
   input  rob_id_t          lsb_id,
   input  logic [XLEN-1:0]  lsb_res,
   input  logic             commit_ok,
   input  rob_id_t          commit_id,
   input  logic [XLEN-1:0]  commit_res,
   output slot_state_e      dbg_state
);

   slot_state_e state_q, state_d;
   slot_t       slot_q, slot_d;

   logic held, target_full, issue_fire, ready, accept;

   bcast_t   acc_alu, acc_lsb, acc_cmt;
   bcast_t   snp_alu, snp_lsb, snp_cmt;
   operand_t acc_pre1, acc_pre2, acc_bus1, acc_bus2, acc_op1, acc_op2;
   operand_t fwd_op1, fwd_op2;

   assign held = (state_q == SLOT_HELD);

   // Broadcasts are ignored while frozen; the snoop copy also only sees them while held.
   always_comb begin
      acc_alu = '{valid: alu_ok    && rdy, id: alu_id,    value: alu_res};
      acc_lsb = '{valid: lsb_ok    && rdy, id: lsb_id,    value: lsb_res};
      acc_cmt = '{valid: commit_ok && rdy, id: commit_id, value: commit_res};
      snp_alu = acc_alu;
      snp_lsb = acc_lsb;
      snp_cmt = acc_cmt;
      snp_alu.valid = acc_alu.valid && held;
      snp_lsb.valid = acc_lsb.valid && held;
      snp_cmt.valid = acc_cmt.valid && held;
   end

   assign acc_pre1 = rf_lookup(dif.inst_use_rs1, dif.inst_rs1, rf_busy1, rf_tag1, rf_val1);
   assign acc_pre2 = rf_lookup(dif.inst_use_rs2, dif.inst_rs2, rf_busy2, rf_tag2, rf_val2);

   operand_resolve u_acc1 (.in_op(acc_pre1), .alu_bc(acc_alu), .lsb_bc(acc_lsb),
                           .commit_bc(acc_cmt), .out_op(acc_bus1));
   operand_resolve u_acc2 (.in_op(acc_pre2), .alu_bc(acc_alu), .lsb_bc(acc_lsb),
                           .commit_bc(acc_cmt), .out_op(acc_bus2));
   operand_resolve u_fwd1 (.in_op(slot_q.op1), .alu_bc(snp_alu), .lsb_bc(snp_lsb),
                           .commit_bc(snp_cmt), .out_op(fwd_op1));
   operand_resolve u_fwd2 (.in_op(slot_q.op2), .alu_bc(snp_alu), .lsb_bc(snp_lsb),
                           .commit_bc(snp_cmt), .out_op(fwd_op2));

   // A finished ROB entry is the last resort, after a same-cycle broadcast.
   always_comb begin
      acc_op1 = acc_bus1;
      acc_op2 = acc_bus2;
      if (!acc_bus1.r && rob_rdy1) begin
         acc_op1.r = 1'b1;
         acc_op1.v = rob_val1;
         acc_op1.q = '0;
      end
      if (!acc_bus2.r && rob_rdy2) begin
         acc_op2.r = 1'b1;
         acc_op2.v = rob_val2;
         acc_op2.q = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= SLOT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (rdy) begin
         if (clear) begin
            state_d = SLOT_EMPTY;
         end else if (accept) begin
            state_d = SLOT_HELD;
         end else if (issue_fire) begin
            state_d = SLOT_EMPTY;
         end
      end
   end

   // Control outputs; rst low suppresses everything so a held entry never issues.
   always_comb begin
      target_full = slot_q.is_mem ? lsb_full : rs_full;
      issue_fire  = rst && rdy && !clear && held && !target_full;
      ready       = rst && rdy && !clear && !rob_full && (!held || issue_fire);
      accept      = dif.inst_valid && ready;
      rob_alloc   = accept;
      rename_en   = accept && (dif.inst_rd != '0);
      rename_rd   = dif.inst_rd;
      rename_tag  = rob_tail;
   end

   always_comb begin
      slot_d = slot_q;
      if (rdy && !clear) begin
         if (accept) begin
            slot_d.opcode = dif.inst_opcode;
            slot_d.rob_id = rob_tail;
            slot_d.is_mem = dif.inst_is_mem;
            slot_d.imm    = dif.inst_imm;
            slot_d.pc     = dif.inst_pc;
            slot_d.op1    = acc_op1;
            slot_d.op2    = acc_op2;
         end else if (held) begin
            slot_d.op1 = fwd_op1;
            slot_d.op2 = fwd_op2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign rf_rs1    = dif.inst_rs1;
   assign rf_rs2    = dif.inst_rs2;
   assign rob_q1    = rf_tag1;
   assign rob_q2    = rf_tag2;
   assign dbg_state = state_q;

   assign dif.inst_ready   = ready;
   assign dif.is_issue     = issue_fire && !slot_q.is_mem;
   assign dif.lsb_issue    = issue_fire &&  slot_q.is_mem;
   assign dif.issue_opcode = slot_q.opcode;
   assign dif.issue_rob_id = slot_q.rob_id;
   assign dif.issue_Vi     = fwd_op1.v;
   assign dif.issue_Qi     = fwd_op1.q;
   assign dif.issue_Ri     = fwd_op1.r;
   assign dif.issue_Vj     = fwd_op2.v;
   assign dif.issue_Qj     = fwd_op2.q;
   assign dif.issue_Rj     = fwd_op2.r;
   assign dif.issue_imm    = slot_q.imm;
   assign dif.issue_pc     = slot_q.pc;

endmodule

// File: tb/tb_dispatcher.sv
// Randomized and directed bench for the dispatcher, checked against an
// instruction-level reference model through per-cycle and per-issue queues.
module tb_dispatcher;
   import dispatcher_pkg::*;

   localparam int PW = 148;
   localparam int SW = 32;

   logic clk = 1'b0;
   logic rst, rdy, clear;
   logic [4:0]  rf_rs1, rf_rs2;
   logic        rf_busy1, rf_busy2;
   logic [3:0]  rf_tag1, rf_tag2;
   logic [31:0] rf_val1, rf_val2;
   logic [3:0]  rob_q1, rob_q2;
   logic        rob_rdy1, rob_rdy2;
   logic [31:0] rob_val1, rob_val2;
   logic        rob_full;
   logic [3:0]  rob_tail;
   logic        rob_alloc, rename_en;
   logic [4:0]  rename_rd;
   logic [3:0]  rename_tag;
   logic        rs_full, lsb_full;
   logic        alu_ok, lsb_ok, commit_ok;
   logic [3:0]  alu_id, lsb_id, commit_id;
   logic [31:0] alu_res, lsb_res, commit_res;
   slot_state_e dbg_state;

   dispatcher_if dif();

   dispatcher dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .dif(dif),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .rf_busy1(rf_busy1), .rf_busy2(rf_busy2), .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
      .rf_val1(rf_val1), .rf_val2(rf_val2), .rob_q1(rob_q1), .rob_q2(rob_q2),
      .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2), .rob_val1(rob_val1), .rob_val2(rob_val2),
      .rob_full(rob_full), .rob_tail(rob_tail), .rob_alloc(rob_alloc),
      .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
      .rs_full(rs_full), .lsb_full(lsb_full),
      .alu_ok(alu_ok), .alu_id(alu_id), .alu_res(alu_res),
      .lsb_ok(lsb_ok), .lsb_id(lsb_id), .lsb_res(lsb_res),
      .commit_ok(commit_ok), .commit_id(commit_id), .commit_res(commit_res),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, rdy, clear, inst_valid;
      logic [5:0] opcode;
      logic [4:0] rd, rs1, rs2;
      logic use1, use2, is_mem;
      logic [31:0] imm, pc;
      logic busy1, busy2;
      logic [3:0] tag1, tag2;
      logic [31:0] rfv1, rfv2;
      logic robr1, robr2;
      logic [31:0] robv1, robv2;
      logic rob_full;
      logic [3:0] rob_tail;
      logic rs_full, lsb_full;
      logic alu_ok, lsb_ok, commit_ok;
      logic [3:0] alu_id, lsb_id, commit_id;
      logic [31:0] alu_res, lsb_res, commit_res;
   } stim_t;

   typedef struct {
      logic r;
      logic [31:0] v;
      logic [3:0] q;
   } opnd_t;

   logic [PW-1:0] exp_q[$];
   logic [SW-1:0] strobe_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the instruction waiting to issue, if any.
   logic        m_held = 1'b0;
   logic [5:0]  m_opcode;
   logic [3:0]  m_rob_id;
   logic        m_is_mem;
   logic [31:0] m_imm, m_pc;
   opnd_t       m_op[2];

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic opnd_t snoop(input opnd_t o, input stim_t s);
      opnd_t n;
      n = o;
      if (!o.r) begin
         if (s.alu_ok && s.alu_id == o.q) begin
            n.r = 1'b1; n.v = s.alu_res; n.q = 4'd0;
         end else if (s.lsb_ok && s.lsb_id == o.q) begin
            n.r = 1'b1; n.v = s.lsb_res; n.q = 4'd0;
         end else if (s.commit_ok && s.commit_id == o.q) begin
            n.r = 1'b1; n.v = s.commit_res; n.q = 4'd0;
         end
      end
      return n;
   endfunction

   function automatic opnd_t lookup(input logic use_op, input logic [4:0] rs, input logic busy,
                                    input logic [3:0] tag, input logic [31:0] rfv,
                                    input logic robr, input logic [31:0] robv, input stim_t s);
      opnd_t o;
      o.r = 1'b1; o.v = 32'd0; o.q = 4'd0;
      if (use_op && rs != 5'd0) begin
         if (!busy) begin
            o.v = rfv;
         end else begin
            o.r = 1'b0; o.q = tag;
            o = snoop(o, s);
            if (!o.r && robr) begin
               o.r = 1'b1; o.v = robv; o.q = 4'd0;
            end
         end
      end
      return o;
   endfunction

   task automatic model_step(input stim_t s);
      logic live, can_issue, ready, accept, ren;
      live      = s.rst && s.rdy && !s.clear;
      can_issue = live && m_held && !(m_is_mem ? s.lsb_full : s.rs_full);
      ready     = live && !s.rob_full && (!m_held || can_issue);
      accept    = s.inst_valid && ready;
      ren       = accept && (s.rd != 5'd0);
      strobe_q.push_back({ready, can_issue && !m_is_mem, can_issue && m_is_mem, accept, ren,
                          ren ? s.rd : 5'd0, ren ? s.rob_tail : 4'd0,
                          s.rs1, s.rs2, s.tag1, s.tag2});
      if (s.rst && s.rdy && m_held) begin
         m_op[0] = snoop(m_op[0], s);
         m_op[1] = snoop(m_op[1], s);
      end
      if (can_issue)
         exp_q.push_back({m_opcode, m_rob_id, m_op[0].v, m_op[0].q, m_op[0].r,
                          m_op[1].v, m_op[1].q, m_op[1].r, m_imm, m_pc});
      if (!s.rst) begin
         m_held = 1'b0;
      end else if (s.rdy) begin
         if (s.clear) begin
            m_held = 1'b0;
         end else if (accept) begin
            m_held   = 1'b1;
            m_opcode = s.opcode;
            m_rob_id = s.rob_tail;
            m_is_mem = s.is_mem;
            m_imm    = s.imm;
            m_pc     = s.pc;
            m_op[0]  = lookup(s.use1, s.rs1, s.busy1, s.tag1, s.rfv1, s.robr1, s.robv1, s);
            m_op[1]  = lookup(s.use2, s.rs2, s.busy2, s.tag2, s.rfv2, s.robr2, s.robv2, s);
         end else if (can_issue) begin
            m_held = 1'b0;
         end
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      s.rst = 1'b1;
      s.rdy = 1'b1;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s = idle();
      s.rst        = ($urandom_range(63) != 0);
      s.rdy        = ($urandom_range(7) != 0);
      s.clear      = ($urandom_range(15) == 0);
      s.inst_valid = ($urandom_range(3) != 0);
      s.is_mem     = ($urandom_range(2) == 0);
      s.opcode     = s.is_mem ? OP_LW : OP_ADD;
      s.rd         = 5'($urandom_range(7));
      s.rs1        = 5'($urandom_range(7));
      s.rs2        = 5'($urandom_range(7));
      s.use1       = ($urandom_range(3) != 0);
      s.use2       = ($urandom_range(1) != 0);
      s.imm        = $urandom;
      s.pc         = $urandom;
      s.busy1      = ($urandom_range(1) != 0);
      s.busy2      = ($urandom_range(1) != 0);
      s.tag1       = 4'($urandom_range(3));
      s.tag2       = 4'($urandom_range(3));
      s.rfv1       = $urandom;
      s.rfv2       = $urandom;
      s.robr1      = ($urandom_range(3) == 0);
      s.robr2      = ($urandom_range(3) == 0);
      s.robv1      = $urandom;
      s.robv2      = $urandom;
      s.rob_full   = ($urandom_range(7) == 0);
      s.rob_tail   = 4'($urandom_range(15));
      s.rs_full    = ($urandom_range(2) == 0);
      s.lsb_full   = ($urandom_range(2) == 0);
      s.alu_ok     = ($urandom_range(2) == 0);
      s.lsb_ok     = ($urandom_range(2) == 0);
      s.commit_ok  = ($urandom_range(2) == 0);
      s.alu_id     = 4'($urandom_range(3));
      s.lsb_id     = 4'($urandom_range(3));
      s.commit_id  = 4'($urandom_range(3));
      s.alu_res    = $urandom;
      s.lsb_res    = $urandom;
      s.commit_res = $urandom;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rst = s.rst; rdy = s.rdy; clear = s.clear;
      dif.inst_valid = s.inst_valid; dif.inst_opcode = s.opcode; dif.inst_rd = s.rd;
      dif.inst_rs1 = s.rs1; dif.inst_rs2 = s.rs2; dif.inst_use_rs1 = s.use1;
      dif.inst_use_rs2 = s.use2; dif.inst_is_mem = s.is_mem;
      dif.inst_imm = s.imm; dif.inst_pc = s.pc;
      rf_busy1 = s.busy1; rf_busy2 = s.busy2; rf_tag1 = s.tag1; rf_tag2 = s.tag2;
      rf_val1 = s.rfv1; rf_val2 = s.rfv2; rob_rdy1 = s.robr1; rob_rdy2 = s.robr2;
      rob_val1 = s.robv1; rob_val2 = s.robv2; rob_full = s.rob_full; rob_tail = s.rob_tail;
      rs_full = s.rs_full; lsb_full = s.lsb_full;
      alu_ok = s.alu_ok; alu_id = s.alu_id; alu_res = s.alu_res;
      lsb_ok = s.lsb_ok; lsb_id = s.lsb_id; lsb_res = s.lsb_res;
      commit_ok = s.commit_ok; commit_id = s.commit_id; commit_res = s.commit_res;
   endtask

   task automatic step(input stim_t s);
      apply(s);
      model_step(s);
      @(posedge clk);
      #1;
   endtask

   // Monitor: mid-cycle compare of control outputs and of every issued payload.
   initial begin
      logic [SW-1:0] e_s, a_s;
      logic [PW-1:0] e_p, a_p;
      forever begin
         @(negedge clk);
         if (strobe_q.size() != 0) begin
            e_s = strobe_q.pop_front();
            a_s = {dif.inst_ready, dif.is_issue, dif.lsb_issue, rob_alloc, rename_en,
                   rename_en ? rename_rd : 5'd0, rename_en ? rename_tag : 4'd0,
                   rf_rs1, rf_rs2, rob_q1, rob_q2};
            check("strobes", PW'(a_s), PW'(e_s));
            if (dif.is_issue || dif.lsb_issue) begin
               a_p = {dif.issue_opcode, dif.issue_rob_id, dif.issue_Vi, dif.issue_Qi, dif.issue_Ri,
                      dif.issue_Vj, dif.issue_Qj, dif.issue_Rj, dif.issue_imm, dif.issue_pc};
               if (exp_q.size() == 0) begin
                  check("issue_unexpected", a_p, '1);
               end else begin
                  e_p = exp_q.pop_front();
                  check("payload", a_p, e_p);
               end
            end
         end
      end
   end

   initial begin
      stim_t s;
      @(posedge clk);
      #1;
      s = idle(); s.rst = 1'b0; s.inst_valid = 1'b1; s.rs_full = 1'b0;
      repeat (3) step(s);
      @(negedge clk);
      check("reset_payload", {dif.issue_opcode, dif.issue_rob_id, dif.issue_Vi, dif.issue_Qi,
                              dif.issue_Ri, dif.issue_Vj, dif.issue_Qj, dif.issue_Rj,
                              dif.issue_imm, dif.issue_pc}, '0);
      check("reset_state", PW'(dbg_state), PW'(SLOT_EMPTY));
      @(posedge clk);
      #1;

      // Independent add x3,x1,x2
      s = idle(); s.inst_valid = 1'b1; s.opcode = OP_ADD; s.rd = 5'd3; s.rs1 = 5'd1; s.rs2 = 5'd2;
      s.use1 = 1'b1; s.use2 = 1'b1; s.rfv1 = 32'd5; s.rfv2 = 32'd7; s.rob_tail = 4'd5; s.pc = 32'h100;
      step(s);
      s = idle(); step(s);

      // rs1 waits on tag 4, woken by alu in the issue cycle
      s = idle(); s.inst_valid = 1'b1; s.opcode = OP_ADD; s.rd = 5'd4; s.rs1 = 5'd1; s.rs2 = 5'd2;
      s.use1 = 1'b1; s.use2 = 1'b1; s.busy1 = 1'b1; s.tag1 = 4'd4; s.rfv2 = 32'd3; s.rob_tail = 4'd6;
      step(s);
      s = idle(); s.alu_ok = 1'b1; s.alu_id = 4'd4; s.alu_res = 32'h99; step(s);

      // rs2 waits on tag 2 through a three-cycle rs_full stall
      s = idle(); s.inst_valid = 1'b1; s.opcode = OP_SUB; s.rd = 5'd5; s.rs2 = 5'd2;
      s.use2 = 1'b1; s.busy2 = 1'b1; s.tag2 = 4'd2; s.rob_tail = 4'd8;
      step(s);
      s = idle(); s.rs_full = 1'b1; step(s);
      s.lsb_ok = 1'b1; s.lsb_id = 4'd2; s.lsb_res = 32'h1234; step(s);
      s.lsb_ok = 1'b0; step(s);
      s = idle(); step(s);

      // Load then a dependent add back-to-back
      s = idle(); s.inst_valid = 1'b1; s.opcode = OP_LW; s.is_mem = 1'b1; s.rd = 5'd6; s.rs1 = 5'd2;
      s.use1 = 1'b1; s.rfv1 = 32'h100; s.imm = 32'd4; s.rob_tail = 4'd7; s.rs_full = 1'b1;
      step(s);
      s = idle(); s.inst_valid = 1'b1; s.opcode = OP_ADD; s.rd = 5'd7; s.rs1 = 5'd6; s.use1 = 1'b1;
      s.busy1 = 1'b1; s.tag1 = 4'd7; s.rob_tail = 4'd8;
      step(s);
      s = idle(); step(s);

      // clear while held and with a new instruction offered
      s = idle(); s.inst_valid = 1'b1; s.opcode = OP_ADD; s.rd = 5'd1; s.rob_tail = 4'd9; s.rs_full = 1'b1;
      step(s);
      s.clear = 1'b1; s.rs_full = 1'b0; s.rob_tail = 4'd10; step(s);
      s = idle(); step(s);
      step(s);

      // rob_full blocks accept; then rs1=x0 reads zero
      s = idle(); s.inst_valid = 1'b1; s.opcode = OP_ADDI; s.rd = 5'd2; s.rs1 = 5'd0; s.use1 = 1'b1;
      s.rfv1 = 32'hdead; s.imm = 32'd11; s.rob_full = 1'b1; s.rob_tail = 4'd11;
      step(s);
      s.rob_full = 1'b0; step(s);
      s = idle(); step(s);

      for (int i = 0; i < 3000; i++) step(rand_stim());

      s = idle();
      repeat (4) step(s);
      @(negedge clk);
      #1;
      check("issue_queue_drained", PW'(exp_q.size()), '0);
      check("strobe_queue_drained", PW'(strobe_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
